clk_ratio_meter: RTL
====================

// Module: clk_ratio_meter
// PURPOSE
//   Measures a slow or divided clock-like signal against the fast system clock.
//   Reports period, high time and a lock/timeout status in system-clock cycles.
//   Sits on the consuming side of the divided-clock outputs.
//   Checks the /2../16 ratios in-system and qualifies any external slow strobe.
// PARAMETERS
//   CNT_W       16  width of cycle counter and of period/high_time outputs
//   SYNC_STAGES 2   flops in the sig_in synchronizer (legal >= 2)
//   LOCK_COUNT  4   consecutive matching periods required to assert locked
//   TOL         1   max |period - previous period| still counted as a match
// PORTS
//   clk          in   1      system clock, all logic on posedge
//   reset        in   1      asynchronous, active-high; clears all state
//   sig_in       in   1      signal under measurement, asynchronous to clk
//   period       out  CNT_W  clk cycles between last two sig_in rising edges
//   high_time    out  CNT_W  clk cycles from last rising to following falling edge
//   period_valid out  1      one-cycle pulse: period/high_time just updated
//   locked       out  1      LOCK_COUNT consecutive periods within TOL
//   timeout      out  1      no rising edge within 2^CNT_W-1 cycles; sticky
// BEHAVIOUR
//   Reset: all outputs 0; synchronizer and edge-history flops 0; cnt=0; FSM=IDLE.
//   Sync/edge detect:
//     - sig_in passes SYNC_STAGES flops, then one history flop s_d.
//     - rise = s & ~s_d; fall = ~s & s_d.
//     - Latency from sig_in edge to rise/fall detect is SYNC_STAGES+1 cycles.
//   Counter cnt:
//     - Loads 1 on a rise cycle; otherwise increments.
//     - Saturates at 2^CNT_W-1.
//     - A rise at cycle t and the next rise at t+P leave cnt==P in cycle t+P.
//   FSM states:
//     - IDLE: cnt is ignored. A rise goes to MEASURE and clears timeout.
//       No period is reported.
//     - MEASURE: on fall, high_time <= cnt.
//       On rise: period <= cnt and period_valid <= 1 in the next cycle.
//       Compare cnt with prev_period:
//         match (|diff|<=TOL) -> match_cnt++;
//         mismatch -> match_cnt <= 0.
//       Then prev_period <= cnt.
//       When match_cnt reaches LOCK_COUNT-1 on a matching rise, go to
//       LOCKED and set locked <= 1.
//     - LOCKED: same updates as MEASURE.
//       A mismatching rise clears locked and match_cnt and returns to MEASURE.
//     - Any state except IDLE: cnt at saturation with no rise goes to IDLE.
//       Sets timeout <= 1 and locked <= 0.
//       period and high_time hold their last values.
//   Simultaneous events: a rise and saturation in the same cycle counts as a
//   rise; no timeout is raised.
//   The first period after IDLE is reported but never counts as a match,
//   because prev_period is not yet valid.
//   Minimum measurable period is 2 cycles (sig_in = clk/2).
//   Shorter or aliased input is undefined but must not hang the FSM.
//   Reset asserted mid-measurement returns everything to reset values
//   immediately (async). After release, the first rise restarts from IDLE.
//   Outputs are registered; period_valid is never high two cycles in a row.
// TESTING
//   1. Reset, then sig_in = clk/4 (2 high, 2 low):
//      period_valid pulses every 4 cycles with period=4 and high_time=2.
//      locked=1 on the 5th rise; timeout=0.
//   2. sig_in = clk/16, then switched to clk/8 while locked:
//      the first period=8 report drops locked to 0.
//      locked re-asserts after 4 matching periods of 8.
//   3. CNT_W=8 with sig_in held low after lock:
//      timeout=1 and locked=0 about 255 cycles after the last rise.
//      Outputs keep period=16; the next rise clears timeout and reports nothing.
//   4. Jitter: periods alternate 9/10 with TOL=1, so locked asserts.
//      Periods alternating 9/11 never lock.
//   5. Assert reset mid-high-phase while locked:
//      all outputs go 0 in the same cycle, without waiting for a clk edge.
//      After release, sig_in=clk/2 gives period=2 and high_time=1.
//   6. sig_in rising exactly as cnt saturates:
//      the rise wins, with no timeout and period=2^CNT_W-1.

Source files
------------

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous slow signal in clk cycles.
// Also reports lock, when consecutive periods agree within TOL, and a sticky timeout.
module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam int              MC_W    = $clog2(LOCK_COUNT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [CNT_W-1:0]       cnt, prev_period, diff;
    logic                   prev_valid, match, lock_hit;
    logic [MC_W-1:0]        match_cnt;
    logic [1:0]             state;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (rise)
            cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

    // prev_valid keeps the first period after IDLE from ever counting as a match
    assign diff     = (cnt >= prev_period) ? (cnt - prev_period) : (prev_period - cnt);
    assign match    = prev_valid && (diff <= TOL_C);
    assign lock_hit = (int'(match_cnt) + 1) >= (LOCK_COUNT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            prev_period  <= '0;
            prev_valid   <= 1'b0;
            match_cnt    <= '0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= MEASURE;
                        timeout    <= 1'b0;
                        prev_valid <= 1'b0;
                        match_cnt  <= '0;
                    end
                end
                MEASURE, LOCKED: begin
                    // a rise outranks saturation, so a period of exactly CNT_MAX is reported
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        prev_period  <= cnt;
                        prev_valid   <= 1'b1;
                        if (match) begin
                            if (int'(match_cnt) < LOCK_COUNT - 1)
                                match_cnt <= match_cnt + MC_W'(1);
                            if (state == MEASURE && lock_hit) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            state     <= MEASURE;
                        end
                    end else if (cnt == CNT_MAX) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                    end else if (fall) begin
                        high_time <= cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
